// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU, secondary (DMA/debug) and memory-side
// signals of the unified memory port arbiter.
//   slave  : the arbiter's view (accepts requester accesses, drives memory)
//   master : the environment's view (requesters and the memory itself)
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // CPU requester
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_done;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    // Secondary requester (DMA, debug loader, backdoor)
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_done;
    logic [DATA_WIDTH-1:0] dma_rdata;

    // Memory side
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ready;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_err;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_done, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_done, dma_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_err,
        input  mem_ready, mem_rdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_done, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_done, dma_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_err,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between the
// multi-cycle CPU and a secondary requester. One access at a time, round-robin
// on ties (CPU wins the first tie after reset), req/ready handshake towards
// memory and a one-cycle done pulse back to the requester that owned the access.
//
// Build option: define MEM_ARB_TIMEOUT_EN to add a mem_ready watchdog. After
// TIMEOUT_CYCLES stalled BUSY cycles the access is abandoned, the owner sees
// done with rdata=0 and the sticky mem_err flag sets until reset. Without the
// macro BUSY waits for mem_ready indefinitely and mem_err is tied low.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    // Round-robin pick, only meaningful when at least one request is up:
    // returns 1 when the secondary requester gets the port.
    function automatic logic pick_dma(input logic cpu_req,
                                      input logic dma_req,
                                      input logic last_dma);
        logic p;
        if (cpu_req && dma_req) begin
            p = !last_dma;
        end else begin
            p = dma_req;
        end
        return p;
    endfunction

    state_t                state_q,     state_d;
    owner_t                owner_q,     owner_d;
    logic                  last_dma_q,  last_dma_d;   // 1: DMA was granted most recently
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  cpu_done_q,  cpu_done_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic                  dma_done_q,  dma_done_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;

    logic any_req;
    logic grant_dma;

`ifdef MEM_ARB_TIMEOUT_EN
    // Wide enough to hold TIMEOUT_CYCLES itself.
    localparam int TMO_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             mem_err_q, mem_err_d;
`else
    // The watchdog limit has no meaning in this build.
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES == 0);
`endif

    // Arbitration decision for the current IDLE cycle.
    always_comb begin
        any_req   = bus.cpu_req | bus.dma_req;
        grant_dma = pick_dma(bus.cpu_req, bus.dma_req, last_dma_q);
    end

    // Next-state and registered-output logic for the IDLE/BUSY/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_dma_d  = last_dma_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_done_d  = 1'b0;
        dma_rdata_d = dma_rdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        mem_err_d   = mem_err_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                // A req still high here is always a fresh access.
                if (any_req) begin
                    state_d   = ST_BUSY;
                    mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                    if (grant_dma) begin
                        owner_d     = OWN_DMA;
                        last_dma_d  = 1'b1;
                        mem_we_d    = bus.dma_we;
                        mem_addr_d  = bus.dma_addr;
                        mem_wdata_d = bus.dma_wdata;
                    end else begin
                        owner_d     = OWN_CPU;
                        last_dma_d  = 1'b0;
                        mem_we_d    = bus.cpu_we;
                        mem_addr_d  = bus.cpu_addr;
                        mem_wdata_d = bus.cpu_wdata;
                    end
                end
            end

            ST_BUSY: begin
                // Memory-side fields stay frozen; only mem_ready (or the
                // watchdog) moves us on. Requester inputs are not looked at.
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_DONE;
                    if (owner_q == OWN_CPU) begin
                        cpu_done_d = 1'b1;
                        if (!mem_we_q) begin
                            cpu_rdata_d = bus.mem_rdata;
                        end
                    end else if (owner_q == OWN_DMA) begin
                        dma_done_d = 1'b1;
                        if (!mem_we_q) begin
                            dma_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (tmo_cnt_q == TMO_LAST) begin
                        // Give up: the owner still gets its done, with zero data.
                        mem_req_d = 1'b0;
                        state_d   = ST_DONE;
                        mem_err_d = 1'b1;
                        if (owner_q == OWN_CPU) begin
                            cpu_done_d  = 1'b1;
                            cpu_rdata_d = '0;
                        end else if (owner_q == OWN_DMA) begin
                            dma_done_d  = 1'b1;
                            dma_rdata_d = '0;
                        end
                    end
`endif
                end
            end

            ST_DONE: begin
                // done is high during this cycle; release the port.
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end

            default: begin
                state_d   = ST_IDLE;
                owner_d   = OWN_NONE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            last_dma_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            dma_done_q  <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_dma_q  <= last_dma_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_done_q  <= dma_done_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog counter and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.mem_err = mem_err_q;
`else
    assign bus.mem_err = 1'b0;
`endif

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter
// against a transaction-level timeline model (grant by round robin, memory
// answers after a chosen latency, done one cycle after ready, port free the
// cycle after done). The watchdog section is active only when the bench is
// built with MEM_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;     // idle cycles before this request is raised
    } txn_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    txn_t        cpu_q[$];
    txn_t        dma_q[$];
    int          cpu_wait = 0;
    int          dma_wait = 0;
    logic [31:0] mem_model [logic [31:0]];
    int          done_log[$];

    // Timeline model of the port
    int          m_owner = -1;   // -1 free, 0 CPU, 1 DMA
    int          m_last  = 1;    // requester granted most recently
    int          m_grant_cyc = 0;
    int          m_ready_cyc = 0;
    int          m_free  = 0;    // first cycle in which the port samples requests
    txn_t        m_cur;
    logic [31:0] m_rd_val = '0;
    logic [31:0] exp_cpu_rdata = '0;
    logic [31:0] exp_dma_rdata = '0;
    logic        exp_err = 1'b0;
    int          lat_fixed = 0;  // 0: random latency 1..4

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] a,
                                input logic [31:0] d, input int g);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.gap = g;
        return t;
    endfunction

    function automatic txn_t rand_txn(input int max_gap);
        return mk(1'($urandom), 32'h1000 + 32'(4 * $urandom_range(0, 15)),
                  $urandom, int'($urandom_range(0, max_gap)));
    endfunction

    task automatic drive_idle();
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_idle();
        tick();
        check("rst_cpu_done", 32'(bus.cpu_done), 32'd0);
        tick();
        check("rst_mem_req",   32'(bus.mem_req),  32'd0);
        check("rst_mem_we",    32'(bus.mem_we),   32'd0);
        check("rst_mem_addr",  bus.mem_addr,      32'd0);
        check("rst_mem_wdata", bus.mem_wdata,     32'd0);
        check("rst_cpu_done2", 32'(bus.cpu_done), 32'd0);
        check("rst_dma_done",  32'(bus.dma_done), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata,     32'd0);
        check("rst_dma_rdata", bus.dma_rdata,     32'd0);
        check("rst_mem_err",   32'(bus.mem_err),  32'd0);
        reset = 1'b0;
        m_owner = -1; m_last = 1; m_free = cyc;
        exp_cpu_rdata = '0; exp_dma_rdata = '0; exp_err = 1'b0;
        cpu_wait = 0; dma_wait = 0;
        done_log.delete();
    endtask

    // Runs the queued transactions cycle by cycle, checking every cycle.
    task automatic run(input int budget);
        int  n = 0;
        bit  in_busy, is_done, cpu_on, dma_on, pend;
        while ((cpu_q.size() != 0 || dma_q.size() != 0 || m_owner != -1) && n < budget) begin
            // Observe the current cycle
            is_done = (m_owner != -1) && (cyc == m_ready_cyc + 1);
            in_busy = (m_owner != -1) && (cyc > m_grant_cyc) && (cyc <= m_ready_cyc);
            if (is_done && !m_cur.we) begin
                if (m_owner == 0) exp_cpu_rdata = m_rd_val;
                else              exp_dma_rdata = m_rd_val;
            end
            check("mem_req", 32'(bus.mem_req), 32'(in_busy));
            if (in_busy) begin
                check("mem_addr",  bus.mem_addr,     m_cur.addr);
                check("mem_we",    32'(bus.mem_we),  32'(m_cur.we));
                check("mem_wdata", bus.mem_wdata,    m_cur.wdata);
            end
            check("cpu_done",  32'(bus.cpu_done), 32'(is_done && m_owner == 0));
            check("dma_done",  32'(bus.dma_done), 32'(is_done && m_owner == 1));
            check("cpu_rdata", bus.cpu_rdata,     exp_cpu_rdata);
            check("dma_rdata", bus.dma_rdata,     exp_dma_rdata);
            check("mem_err",   32'(bus.mem_err),  32'(exp_err));
            if (bus.cpu_done) done_log.push_back(0);
            if (bus.dma_done) done_log.push_back(1);
            if (is_done) begin
                if (m_owner == 0) begin
                    void'(cpu_q.pop_front());
                    if (cpu_q.size() != 0) cpu_wait = cpu_q[0].gap;
                end else begin
                    void'(dma_q.pop_front());
                    if (dma_q.size() != 0) dma_wait = dma_q[0].gap;
                end
                m_owner = -1;
                m_free  = cyc + 1;
            end

            // Requesters present their head transaction or idle garbage
            cpu_on = (cpu_q.size() != 0) && (cpu_wait == 0);
            dma_on = (dma_q.size() != 0) && (dma_wait == 0);
            if (cpu_on) begin
                bus.cpu_req = 1'b1; bus.cpu_we = cpu_q[0].we;
                bus.cpu_addr = cpu_q[0].addr; bus.cpu_wdata = cpu_q[0].wdata;
            end else begin
                bus.cpu_req = 1'b0; bus.cpu_we = 1'($urandom);
                bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom;
                if (cpu_wait > 0) cpu_wait--;
            end
            if (dma_on) begin
                bus.dma_req = 1'b1; bus.dma_we = dma_q[0].we;
                bus.dma_addr = dma_q[0].addr; bus.dma_wdata = dma_q[0].wdata;
            end else begin
                bus.dma_req = 1'b0; bus.dma_we = 1'($urandom);
                bus.dma_addr = $urandom; bus.dma_wdata = $urandom;
                if (dma_wait > 0) dma_wait--;
            end

            // Grant by round robin when the port is free
            if (m_owner == -1 && cyc >= m_free && (cpu_on || dma_on)) begin
                if (cpu_on && dma_on) m_owner = 1 - m_last;
                else                  m_owner = dma_on ? 1 : 0;
                m_last      = m_owner;
                m_cur       = (m_owner == 0) ? cpu_q[0] : dma_q[0];
                m_grant_cyc = cyc;
                m_ready_cyc = cyc + ((lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4)));
            end

            // Memory: answer on the chosen cycle, random noise outside accesses
            in_busy = (m_owner != -1) && (cyc > m_grant_cyc) && (cyc <= m_ready_cyc);
            if (in_busy) begin
                if (cyc == m_ready_cyc) begin
                    bus.mem_ready = 1'b1;
                    if (m_cur.we) begin
                        mem_model[m_cur.addr] = m_cur.wdata;
                        bus.mem_rdata = $urandom;
                    end else begin
                        m_rd_val = mem_read(m_cur.addr);
                        bus.mem_rdata = m_rd_val;
                    end
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end else begin
                bus.mem_ready = ($urandom_range(0, 3) == 0);
                bus.mem_rdata = $urandom;
            end
            tick();
            n++;
        end
        pend = (cpu_q.size() != 0) || (dma_q.size() != 0) || (m_owner != -1);
        check("run_drained", 32'(pend), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] dma_before;
        int          busy_n;
        int          done_at;

        reset = 1'b1;
        drive_idle();
        do_reset();

        // CPU read, memory answers in the first BUSY cycle
        mem_model[32'h100] = 32'hDEADBEEF;
        lat_fixed = 1;
        cpu_q.push_back(mk(1'b0, 32'h100, 32'h0, 0));
        run(50);
        check("t1_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        check("t1_n_done",    32'(done_log.size()), 32'd1);
        if (done_log.size() != 0) check("t1_owner", 32'(done_log[0]), 32'd0);

        // Both requesters busy from reset: grants must alternate CPU first
        do_reset();
        lat_fixed = 2;
        for (int i = 0; i < 4; i++) begin
            cpu_q.push_back(rand_txn(0));
            dma_q.push_back(rand_txn(0));
        end
        run(200);
        check("t2_n_done", 32'(done_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < done_log.size(); i++)
            check($sformatf("t2_order%0d", i), 32'(done_log[i]), 32'(i % 2));

        // DMA write with a slow memory
        done_log.delete();
        dma_before = exp_dma_rdata;
        lat_fixed = 5;
        dma_q.push_back(mk(1'b1, 32'h40, 32'h12345678, 0));
        run(50);
        check("t3_dma_rdata", bus.dma_rdata, dma_before);
        check("t3_n_done",    32'(done_log.size()), 32'd1);
        if (done_log.size() != 0) check("t3_owner", 32'(done_log[0]), 32'd1);

        // Reset in the second BUSY cycle of a CPU read
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h200; bus.cpu_wdata = 32'h0;
        bus.mem_ready = 1'b0;
        tick();
        check("t4_busy1", 32'(bus.mem_req), 32'd1);
        tick();
        check("t4_busy2", 32'(bus.mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("t4_req_drop", 32'(bus.mem_req),  32'd0);
        check("t4_no_done",  32'(bus.cpu_done), 32'd0);
        do_reset();
        lat_fixed = 0;
        cpu_q.push_back(rand_txn(0));
        dma_q.push_back(rand_txn(0));
        run(50);
        check("t4_n_done", 32'(done_log.size()), 32'd2);
        if (done_log.size() != 0) check("t4_cpu_first", 32'(done_log[0]), 32'd0);

        // mem_ready while IDLE with nobody asking must do nothing
        for (int i = 0; i < 6; i++) begin
            bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
            bus.mem_ready = 1'b1; bus.mem_rdata = $urandom;
            tick();
            check("t5_mem_req",   32'(bus.mem_req),  32'd0);
            check("t5_cpu_done",  32'(bus.cpu_done), 32'd0);
            check("t5_dma_done",  32'(bus.dma_done), 32'd0);
            check("t5_cpu_rdata", bus.cpu_rdata,     exp_cpu_rdata);
            check("t5_dma_rdata", bus.dma_rdata,     exp_dma_rdata);
        end
        bus.mem_ready = 1'b0;
        cpu_q.push_back(rand_txn(0));
        run(50);

        // Randomized traffic with gaps and variable latency
        do_reset();
        lat_fixed = 0;
        for (int i = 0; i < 25; i++) begin
            cpu_q.push_back(rand_txn(3));
            dma_q.push_back(rand_txn(3));
        end
        run(3000);

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: memory never answers
        do_reset();
        mem_model[32'h300] = 32'hCAFEF00D;
        lat_fixed = 1;
        cpu_q.push_back(mk(1'b0, 32'h300, 32'h0, 0));
        run(50);
        check("t6_pre_rdata", bus.cpu_rdata, 32'hCAFEF00D);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h304; bus.cpu_wdata = 32'h0;
        bus.dma_req = 1'b0; bus.mem_ready = 1'b0;
        busy_n = 0;
        done_at = -1;
        for (int i = 0; i < 30 && done_at < 0; i++) begin
            tick();
            if (bus.mem_req) busy_n++;
            if (bus.cpu_done) begin
                done_at = i;
                bus.cpu_req = 1'b0;
                check("t6_rdata_zero", bus.cpu_rdata,    32'd0);
                check("t6_err_set",    32'(bus.mem_err), 32'd1);
            end
        end
        check("t6_busy_cycles", 32'(busy_n),  32'(TMO));
        check("t6_done_at",     32'(done_at), 32'(TMO));
        tick();
        check("t6_done_width", 32'(bus.cpu_done), 32'd0);
        check("t6_err_sticky", 32'(bus.mem_err),  32'd1);
        m_owner = -1; m_free = cyc;
        exp_cpu_rdata = '0; exp_err = 1'b1;
        lat_fixed = 0;
        for (int i = 0; i < 4; i++) begin
            cpu_q.push_back(rand_txn(1));
            dma_q.push_back(rand_txn(1));
        end
        run(200);
        do_reset();
`else
        busy_n = 0;
        done_at = 0;
        check("t6_err_tied", 32'(bus.mem_err), 32'(busy_n + done_at));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
